// File: rtl/tag_fill_writer.sv
// tag_fill_writer
//   Write side of the L2 tag path. Holds per-set tag, valid, dirty and LRU-age
//   state. On a miss fill it picks a victim way, writes it back when it is
//   dirty, then installs the new tag. Hit "touch" updates refresh the LRU
//   state and mark lines dirty. A combinational lookup port feeds the per-way
//   tag comparators.
//
// Optional feature macro: FILL_STATS_EN
//   defined   -> fill_count / wb_count are free-running 32-bit event counters
//   undefined -> both outputs tie to 0 and no counter registers exist
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   lookup_index               set to read
//   lookup_tags, lookup_valid  tags / valid bits of that set (way w at [w*tagBits +: tagBits])
//   touch_valid/ready          hit update handshake (not accepted while installing)
//   touch_index/way/write      hit location; touch_write marks the line dirty
//   req_valid/ready            miss fill handshake (accepted only when idle)
//   req_tag/index/write        line to install; req_write installs it dirty
//   wb_valid/ready             writeback handshake for a dirty victim
//   wb_tag, wb_index           evicted line address, stable while wb_valid
//   fill_done, fill_way        one-cycle pulse with the way just written
//   fill_count, wb_count       completed fills / writebacks (FILL_STATS_EN)
module tag_fill_writer #(
  parameter int tagBits   = 12,
  parameter int indexBits = 4,
  parameter int wayBits   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [indexBits-1:0]              lookup_index,
  output logic [(2**wayBits)*tagBits-1:0]   lookup_tags,
  output logic [(2**wayBits)-1:0]           lookup_valid,
  input  logic                              touch_valid,
  output logic                              touch_ready,
  input  logic [indexBits-1:0]              touch_index,
  input  logic [wayBits-1:0]                touch_way,
  input  logic                              touch_write,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [tagBits-1:0]                req_tag,
  input  logic [indexBits-1:0]              req_index,
  input  logic                              req_write,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [tagBits-1:0]                wb_tag,
  output logic [indexBits-1:0]              wb_index,
  output logic                              fill_done,
  output logic [wayBits-1:0]                fill_way,
  output logic [31:0]                       fill_count,
  output logic [31:0]                       wb_count
);

  localparam int WAYS  = 2**wayBits;
  localparam int SETS  = 2**indexBits;
  localparam int AGE_W = WAYS*wayBits;

  typedef enum logic [1:0] {IDLE, SELECT, WB, WRITE} state_t;

  state_t                    state;
  logic [WAYS*tagBits-1:0]   tag_mem   [SETS];
  logic [WAYS-1:0]           valid_mem [SETS];
  logic [WAYS-1:0]           dirty_mem [SETS];
  logic [AGE_W-1:0]          age_mem   [SETS];

  logic [tagBits-1:0]        cap_tag;
  logic [indexBits-1:0]      cap_index;
  logic                      cap_write;
  logic [wayBits-1:0]        victim;
  logic [wayBits-1:0]        sel_victim;
  logic                      sel_dirty;

  // Age 0 is most recent. Ages younger than the used way's age move one step
  // older; the used way becomes youngest, so the set stays a permutation.
  function automatic logic [AGE_W-1:0] lru_touch(input logic [AGE_W-1:0] ages,
                                                 input logic [wayBits-1:0] w);
    logic [AGE_W-1:0]   res;
    logic [wayBits-1:0] old_age;
    logic [wayBits-1:0] cur;
    res     = ages;
    old_age = ages[w*wayBits +: wayBits];
    for (int i = 0; i < WAYS; i++) begin
      cur = ages[i*wayBits +: wayBits];
      if (i[wayBits-1:0] == w)
        res[i*wayBits +: wayBits] = '0;
      else if (cur < old_age)
        res[i*wayBits +: wayBits] = cur + wayBits'(1);
      else
        res[i*wayBits +: wayBits] = cur;
    end
    return res;
  endfunction

  // Lowest-numbered invalid way wins; with a full set the oldest way is chosen.
  function automatic logic [wayBits-1:0] pick_victim(input logic [WAYS-1:0] v,
                                                     input logic [AGE_W-1:0] ages);
    logic [wayBits-1:0] res;
    res = '0;
    for (int i = 0; i < WAYS; i++)
      if (ages[i*wayBits +: wayBits] == wayBits'(WAYS-1))
        res = i[wayBits-1:0];
    for (int i = WAYS-1; i >= 0; i--)
      if (!v[i])
        res = i[wayBits-1:0];
    return res;
  endfunction

  assign lookup_tags  = tag_mem[lookup_index];
  assign lookup_valid = valid_mem[lookup_index];

  assign req_ready   = (state == IDLE);
  assign touch_ready = (state != WRITE);

  assign sel_victim = pick_victim(valid_mem[cap_index], age_mem[cap_index]);
  assign sel_dirty  = valid_mem[cap_index][sel_victim] & dirty_mem[cap_index][sel_victim];

  // Array update: the install happens in WRITE, where touches are held off,
  // so the two never target the arrays in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        tag_mem[s]   <= '0;
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          age_mem[s][w*wayBits +: wayBits] <= w[wayBits-1:0];
      end
    end else if (state == WRITE) begin
      tag_mem[cap_index][victim*tagBits +: tagBits] <= cap_tag;
      valid_mem[cap_index][victim]                  <= 1'b1;
      dirty_mem[cap_index][victim]                  <= cap_write;
      age_mem[cap_index] <= lru_touch(age_mem[cap_index], victim);
    end else if (touch_valid) begin
      age_mem[touch_index] <= lru_touch(age_mem[touch_index], touch_way);
      if (touch_write)
        dirty_mem[touch_index][touch_way] <= 1'b1;
    end
  end

  // Fill sequencer. The victim is latched once in SELECT; later touches to the
  // same set change ages/dirty but do not re-pick the victim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_tag   <= '0;
      cap_index <= '0;
      cap_write <= 1'b0;
      victim    <= '0;
      wb_valid  <= 1'b0;
      wb_tag    <= '0;
      wb_index  <= '0;
      fill_done <= 1'b0;
      fill_way  <= '0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_tag   <= req_tag;
            cap_index <= req_index;
            cap_write <= req_write;
            state     <= SELECT;
          end
        end
        SELECT: begin
          victim <= sel_victim;
          if (sel_dirty) begin
            wb_valid <= 1'b1;
            wb_tag   <= tag_mem[cap_index][sel_victim*tagBits +: tagBits];
            wb_index <= cap_index;
            state    <= WB;
          end else begin
            state <= WRITE;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          fill_done <= 1'b1;
          fill_way  <= victim;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILL_STATS_EN
  logic [31:0] fill_cnt;
  logic [31:0] wb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (fill_done)
        fill_cnt <= fill_cnt + 32'd1;
      if (wb_valid && wb_ready)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end

  assign fill_count = fill_cnt;
  assign wb_count   = wb_cnt;
`else
  assign fill_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_tag_fill_writer.sv
// Testbench for tag_fill_writer: directed fills/touches with hand-computed
// victims; expected fills and writebacks are queued at issue time and a
// negedge monitor pops and compares them when the DUT reports them.
module tb_tag_fill_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  lookup_index;
  logic [47:0] lookup_tags;
  logic [3:0]  lookup_valid;
  logic        touch_valid;
  logic        touch_ready;
  logic [3:0]  touch_index;
  logic [1:0]  touch_way;
  logic        touch_write;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_tag;
  logic [3:0]  req_index;
  logic        req_write;
  logic        wb_valid;
  logic        wb_ready;
  logic [11:0] wb_tag;
  logic [3:0]  wb_index;
  logic        fill_done;
  logic [1:0]  fill_way;
  logic [31:0] fill_count;
  logic [31:0] wb_count;

  tag_fill_writer #(.tagBits(12), .indexBits(4), .wayBits(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_index(lookup_index), .lookup_tags(lookup_tags), .lookup_valid(lookup_valid),
    .touch_valid(touch_valid), .touch_ready(touch_ready), .touch_index(touch_index),
    .touch_way(touch_way), .touch_write(touch_write),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_index(req_index), .req_write(req_write),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_index(wb_index),
    .fill_done(fill_done), .fill_way(fill_way),
    .fill_count(fill_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int fills_seen = 0;
  int exp_fill_n = 0;
  int exp_wb_n = 0;

  typedef struct { logic [1:0] way; int acc; int lat; } fexp_t;
  typedef struct { logic [11:0] tag; logic [3:0] idx; } wexp_t;
  fexp_t fq[$];
  wexp_t wq[$];
  fexp_t fe;
  wexp_t we;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every reported fill and writeback handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fill_done) begin
        if (fq.size() == 0) begin
          chk("fill_unexpected", fill_done, 0);
        end else begin
          fe = fq.pop_front();
          chk("fill_way", fill_way, fe.way);
          chk("fill_latency", cyc - fe.acc, fe.lat);
        end
        fills_seen++;
      end
      if (wb_valid && wb_ready) begin
        if (wq.size() == 0) begin
          chk("wb_unexpected", wb_valid, 0);
        end else begin
          we = wq.pop_front();
          chk("wb_tag", wb_tag, we.tag);
          chk("wb_index", wb_index, we.idx);
        end
      end
    end
  end

  task automatic issue_fill(input logic [11:0] tag, input logic [3:0] idx, input logic wr,
                            input logic [1:0] way, input int lat, input bit push);
    int n = 0;
    @(posedge clk) #1;
    req_valid = 1'b1; req_tag = tag; req_index = idx; req_write = wr;
    while (!req_ready && n < 20) begin @(posedge clk) #1; n++; end
    if (n >= 20) chk("req_accept_timeout", req_ready, 1);
    @(posedge clk) #1;
    req_valid = 1'b0;
    if (push) begin
      fq.push_back('{way, cyc, lat});
      exp_fill_n++;
    end
  endtask

  task automatic wait_fills();
    int n = 0;
    while (fills_seen < exp_fill_n && n < 40) begin @(posedge clk) #1; n++; end
    if (n >= 40) chk("fill_timeout", fills_seen, exp_fill_n);
  endtask

  task automatic fill(input logic [11:0] tag, input logic [3:0] idx, input logic wr,
                      input logic [1:0] way, input int lat);
    issue_fill(tag, idx, wr, way, lat, 1'b1);
    wait_fills();
  endtask

  task automatic push_wb(input logic [11:0] tag, input logic [3:0] idx);
    wq.push_back('{tag, idx});
    exp_wb_n++;
  endtask

  task automatic touch(input logic [3:0] idx, input logic [1:0] way, input logic wr);
    int n = 0;
    @(posedge clk) #1;
    touch_valid = 1'b1; touch_index = idx; touch_way = way; touch_write = wr;
    while (!touch_ready && n < 20) begin @(posedge clk) #1; n++; end
    if (n >= 20) chk("touch_accept_timeout", touch_ready, 1);
    @(posedge clk) #1;
    touch_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; lookup_index = '0;
    touch_valid = 1'b0; touch_index = '0; touch_way = '0; touch_write = 1'b0;
    req_valid = 1'b0; req_tag = '0; req_index = '0; req_write = 1'b0;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset state
    lookup_index = 4'd3;
    #1;
    chk("rst_lookup_valid", lookup_valid, 4'b0000);
    chk("rst_lookup_tags", lookup_tags, 48'h0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_touch_ready", touch_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_fill_count", fill_count, 0);
    chk("rst_wb_count", wb_count, 0);

    // Single clean fill into an empty set
    fill(12'h0AB, 4'd2, 1'b0, 2'd0, 2);
    lookup_index = 4'd2; #1;
    chk("set2_tag_way0", lookup_tags[11:0], 12'h0AB);
    chk("set2_valid", lookup_valid, 4'b0001);

    // Fill set 5, touch way0, then a full-set fill evicts way1 (clean)
    for (int i = 0; i < 4; i++) fill(12'h101 + 12'(i), 4'd5, 1'b0, 2'(i), 2);
    touch(4'd5, 2'd0, 1'b0);
    fill(12'h105, 4'd5, 1'b0, 2'd1, 2);
    lookup_index = 4'd5; #1;
    chk("set5_tags", lookup_tags, 48'h104_103_105_101);
    chk("set5_valid", lookup_valid, 4'hF);

    // Set 7: way3 dirty and oldest; writeback stalled 4 cycles
    fill(12'h301, 4'd7, 1'b0, 2'd0, 2);
    fill(12'h302, 4'd7, 1'b0, 2'd1, 2);
    fill(12'h303, 4'd7, 1'b0, 2'd2, 2);
    fill(12'h304, 4'd7, 1'b1, 2'd3, 2);
    touch(4'd7, 2'd0, 1'b0);
    touch(4'd7, 2'd1, 1'b0);
    touch(4'd7, 2'd2, 1'b0);
    wb_ready = 1'b0;
    push_wb(12'h304, 4'd7);
    issue_fill(12'h200, 4'd7, 1'b0, 2'd3, 7, 1'b1);
    @(posedge clk) #1;
    for (int i = 0; i < 4; i++) begin
      chk("wb_hold_valid", wb_valid, 1);
      chk("wb_hold_tag", wb_tag, 12'h304);
      chk("wb_hold_index", wb_index, 4'd7);
      @(posedge clk) #1;
    end
    wb_ready = 1'b1;
    @(posedge clk) #1;
    chk("wb_drop", wb_valid, 0);
    wait_fills();
    lookup_index = 4'd7; #1;
    chk("set7_tags", lookup_tags, 48'h200_303_302_301);

    // Set 9: touch held off during WRITE, applied next cycle (way0 -> age 0, dirty)
    fill(12'h901, 4'd9, 1'b0, 2'd0, 2);
    fill(12'h902, 4'd9, 1'b0, 2'd1, 2);
    fill(12'h903, 4'd9, 1'b0, 2'd2, 2);
    issue_fill(12'h904, 4'd9, 1'b0, 2'd3, 2, 1'b1);
    @(posedge clk) #1;
    touch_valid = 1'b1; touch_index = 4'd9; touch_way = 2'd0; touch_write = 1'b1;
    #1;
    chk("touch_ready_in_write", touch_ready, 0);
    @(posedge clk) #1;
    chk("touch_ready_after_write", touch_ready, 1);
    @(posedge clk) #1;
    touch_valid = 1'b0; touch_write = 1'b0;
    wait_fills();
    fill(12'h905, 4'd9, 1'b0, 2'd1, 2);
    fill(12'h906, 4'd9, 1'b0, 2'd2, 2);
    fill(12'h907, 4'd9, 1'b0, 2'd3, 2);
    push_wb(12'h901, 4'd9);
    fill(12'h908, 4'd9, 1'b0, 2'd0, 3);
    lookup_index = 4'd9; #1;
    chk("set9_tags", lookup_tags, 48'h907_906_905_908);

    // Statistics counters
    repeat (2) @(posedge clk);
    #1;
`ifdef FILL_STATS_EN
    chk("fill_count", fill_count, 64'(exp_fill_n));
    chk("wb_count", wb_count, 64'(exp_wb_n));
`else
    chk("fill_count", fill_count, 0);
    chk("wb_count", wb_count, 0);
`endif

    // Reset in the middle of a pending writeback
    for (int i = 0; i < 4; i++) fill(12'hC01 + 12'(i), 4'd12, 1'b1, 2'(i), 2);
    wb_ready = 1'b0;
    lookup_index = 4'd12;
    issue_fill(12'hC05, 4'd12, 1'b0, 2'd0, 0, 1'b0);
    @(posedge clk) #1;
    chk("midwb_valid", wb_valid, 1);
    chk("midwb_tag", wb_tag, 12'hC01);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drops_wb_valid", wb_valid, 0);
    chk("rst_clears_valid", lookup_valid, 4'b0000);
    chk("rst_clears_tags", lookup_tags, 48'h0);
    chk("rst_fill_count2", fill_count, 0);
    chk("rst_wb_count2", wb_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_wb_valid", wb_valid, 0);
    chk("fill_queue_empty", fq.size(), 0);
    chk("wb_queue_empty", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
